// File: rtl/decoder_if.sv
// rtl/decoder_if.sv - fetch-to-decode bundle: capture strobe, instruction word and decoded results
//
// Purpose:
//   Groups the signals exchanged between instruction fetch and the decode
//   stage. The fetch side (master) drives the capture enable and the
//   instruction word; the decode stage (slave) returns the registered fields,
//   control strobes and the valid flag.
//
// Signals:
//   en        fetch -> decode  capture instIn on the next rising clk edge
//   instIn    fetch -> decode  8-bit instruction word
//   rs1       decode -> fetch  instIn[7:6]
//   rs2       decode -> fetch  instIn[5:4]
//   fn        decode -> fetch  instIn[3], function-select bit
//   imm       decode -> fetch  instIn[7:4], unsigned immediate
//   opcode    decode -> fetch  instIn[2:0]
//   aluOp     decode -> fetch  ALU operation code
//   regWrite, memRead, memWrite, branchLt, branchEq, jump
//             decode -> fetch  datapath control strobes
//   illegal   decode -> fetch  undefined encoding captured
//   valid     decode -> fetch  outputs hold a freshly captured instruction

interface decoder_if;
  logic       en;
  logic [7:0] instIn;

  logic [1:0] rs1;
  logic [1:0] rs2;
  logic       fn;
  logic [3:0] imm;
  logic [2:0] opcode;
  logic [2:0] aluOp;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       branchLt;
  logic       branchEq;
  logic       jump;
  logic       illegal;
  logic       valid;

  // Fetch side: supplies instructions, observes decode results.
  modport master (
    output en, instIn,
    input  rs1, rs2, fn, imm, opcode, aluOp,
    input  regWrite, memRead, memWrite, branchLt, branchEq, jump,
    input  illegal, valid
  );

  // Decode stage: consumes instructions, produces registered results.
  modport slave (
    input  en, instIn,
    output rs1, rs2, fn, imm, opcode, aluOp,
    output regWrite, memRead, memWrite, branchLt, branchEq, jump,
    output illegal, valid
  );
endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - instruction decode stage of the 8-bit RISC core
//
// Purpose:
//   Splits an 8-bit instruction into register, function and immediate fields
//   and derives the datapath control strobes. Every output is registered, so
//   results appear one clock after the capture edge and there is no
//   combinational path from instIn to any output.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every output at once
//   bus    decoder_if.slave: en/instIn in, fields, strobes, illegal, valid out
//
// Opcode map (instIn[2:0], fn = instIn[3]):
//   000 NAND/NOR  aluOp 000/001, regWrite
//   001 BLT       aluOp 011,     branchLt
//   010 Load      aluOp 010,     memRead + regWrite
//   011 ADD/SUB   aluOp 010/011, regWrite
//   100 SRL/SLL   aluOp 100/101, regWrite
//   101 BEQ       aluOp 011,     branchEq
//   110 Store     aluOp 010,     memWrite
//   111 fn=0 Jump aluOp 111,     jump
//   111 fn=1      undefined:     illegal, aluOp 000, no other strobe

module decoder (
  input  logic     clk,
  input  logic     rst_n,
  decoder_if.slave bus
);

  // Next-state decode of the instruction currently presented.
  logic [2:0] op;
  logic       fn_bit;

  logic [2:0] nxt_alu_op;
  logic       nxt_reg_write;
  logic       nxt_mem_read;
  logic       nxt_mem_write;
  logic       nxt_branch_lt;
  logic       nxt_branch_eq;
  logic       nxt_jump;
  logic       nxt_illegal;

  assign op     = bus.instIn[2:0];
  assign fn_bit = bus.instIn[3];

  always_comb begin
    nxt_alu_op    = 3'b000;
    nxt_reg_write = 1'b0;
    nxt_mem_read  = 1'b0;
    nxt_mem_write = 1'b0;
    nxt_branch_lt = 1'b0;
    nxt_branch_eq = 1'b0;
    nxt_jump      = 1'b0;
    nxt_illegal   = 1'b0;

    unique case (op)
      3'b000: begin
        nxt_alu_op    = fn_bit ? 3'b001 : 3'b000;
        nxt_reg_write = 1'b1;
      end
      3'b001: begin
        nxt_alu_op    = 3'b011;
        nxt_branch_lt = 1'b1;
      end
      3'b010: begin
        nxt_alu_op    = 3'b010;
        nxt_mem_read  = 1'b1;
        nxt_reg_write = 1'b1;
      end
      3'b011: begin
        nxt_alu_op    = fn_bit ? 3'b011 : 3'b010;
        nxt_reg_write = 1'b1;
      end
      3'b100: begin
        nxt_alu_op    = fn_bit ? 3'b101 : 3'b100;
        nxt_reg_write = 1'b1;
      end
      3'b101: begin
        nxt_alu_op    = 3'b011;
        nxt_branch_eq = 1'b1;
      end
      3'b110: begin
        nxt_alu_op    = 3'b010;
        nxt_mem_write = 1'b1;
      end
      3'b111: begin
        // fn=1 under opcode 111 is the only unassigned encoding; it is
        // flagged and suppresses every strobe so nothing downstream acts.
        if (fn_bit) begin
          nxt_illegal = 1'b1;
        end else begin
          nxt_alu_op = 3'b111;
          nxt_jump   = 1'b1;
        end
      end
      default: begin
        nxt_alu_op = 3'b000;
      end
    endcase
  end

  // Output register. Fields are copied raw regardless of opcode, including
  // illegal encodings. With en low everything holds except valid, which
  // drops so the consumer does not act on the same instruction twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rs1      <= 2'b00;
      bus.rs2      <= 2'b00;
      bus.fn       <= 1'b0;
      bus.imm      <= 4'h0;
      bus.opcode   <= 3'b000;
      bus.aluOp    <= 3'b000;
      bus.regWrite <= 1'b0;
      bus.memRead  <= 1'b0;
      bus.memWrite <= 1'b0;
      bus.branchLt <= 1'b0;
      bus.branchEq <= 1'b0;
      bus.jump     <= 1'b0;
      bus.illegal  <= 1'b0;
      bus.valid    <= 1'b0;
    end else if (bus.en) begin
      bus.rs1      <= bus.instIn[7:6];
      bus.rs2      <= bus.instIn[5:4];
      bus.fn       <= bus.instIn[3];
      bus.imm      <= bus.instIn[7:4];
      bus.opcode   <= bus.instIn[2:0];
      bus.aluOp    <= nxt_alu_op;
      bus.regWrite <= nxt_reg_write;
      bus.memRead  <= nxt_mem_read;
      bus.memWrite <= nxt_mem_write;
      bus.branchLt <= nxt_branch_lt;
      bus.branchEq <= nxt_branch_eq;
      bus.jump     <= nxt_jump;
      bus.illegal  <= nxt_illegal;
      bus.valid    <= 1'b1;
    end else begin
      bus.valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for the decode stage

module tb_decoder;

  logic clk;
  logic rst_n;

  decoder_if bus ();

  decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Hand-computed control word per low nibble of 0xA0..0xAF:
  // {aluOp[2:0], regWrite, memRead, memWrite, branchLt, branchEq, jump, illegal}
  logic [9:0] ctrl_tab [16];
  initial begin
    ctrl_tab[0]  = {3'b000, 7'b1000000};  // A0 NAND
    ctrl_tab[1]  = {3'b011, 7'b0001000};  // A1 BLT
    ctrl_tab[2]  = {3'b010, 7'b1100000};  // A2 Load
    ctrl_tab[3]  = {3'b010, 7'b1000000};  // A3 ADD
    ctrl_tab[4]  = {3'b100, 7'b1000000};  // A4 SRL
    ctrl_tab[5]  = {3'b011, 7'b0000100};  // A5 BEQ
    ctrl_tab[6]  = {3'b010, 7'b0010000};  // A6 Store
    ctrl_tab[7]  = {3'b111, 7'b0000010};  // A7 Jump
    ctrl_tab[8]  = {3'b001, 7'b1000000};  // A8 NOR
    ctrl_tab[9]  = {3'b011, 7'b0001000};  // A9 BLT
    ctrl_tab[10] = {3'b010, 7'b1100000};  // AA Load
    ctrl_tab[11] = {3'b011, 7'b1000000};  // AB SUB
    ctrl_tab[12] = {3'b101, 7'b1000000};  // AC SLL
    ctrl_tab[13] = {3'b011, 7'b0000100};  // AD BEQ
    ctrl_tab[14] = {3'b010, 7'b0010000};  // AE Store
    ctrl_tab[15] = {3'b000, 7'b0000001};  // AF undefined
  end

  // Observed layout: {rs1, rs2, fn, imm, opcode, aluOp, 7 strobes, valid}
  function automatic logic [22:0] observed();
    return {bus.rs1, bus.rs2, bus.fn, bus.imm, bus.opcode, bus.aluOp,
            bus.regWrite, bus.memRead, bus.memWrite, bus.branchLt,
            bus.branchEq, bus.jump, bus.illegal, bus.valid};
  endfunction

  // Expected value for an instruction in the 0xA0..0xAF family.
  function automatic logic [22:0] expect_for(input logic [7:0] inst, input logic vld);
    logic [9:0] c;
    c = ctrl_tab[inst[3:0]];
    return {2'd2, 2'd2, inst[3], 4'hA, inst[2:0], c, vld};
  endfunction

  task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present inst at a falling edge, capture on the next rising edge, check
  // at the following falling edge.
  task automatic step(input string tag, input logic [7:0] inst);
    bus.en     = 1'b1;
    bus.instIn = inst;
    @(posedge clk);
    @(negedge clk);
    check(tag, observed(), expect_for(inst, 1'b1));
  endtask

  initial begin
    logic [7:0] code;

    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.instIn = 8'hFF;
    #1;
    check("reset_initial", observed(), 23'd0);

    // Clock edges during reset, even with en high, must not capture.
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_held_en1", observed(), 23'd0);

    // Release with en low: nothing captured.
    rst_n  = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_en0", observed(), 23'd0);

    step("nor_a8",      8'hA8);
    step("nand_a0",     8'hA0);
    step("load_aa",     8'hAA);
    step("store_ae",    8'hAE);
    step("blt_a9",      8'hA9);
    step("blt_a1",      8'hA1);
    step("beq_ad",      8'hAD);
    step("beq_a5",      8'hA5);
    step("jump_a7",     8'hA7);
    step("illegal_af",  8'hAF);

    // Hold: capture SUB, drop en and change the word.
    step("sub_ab", 8'hAB);
    bus.en     = 1'b0;
    bus.instIn = 8'hA3;
    #1;
    check("no_comb_path", observed(), expect_for(8'hAB, 1'b1));
    @(posedge clk);
    @(negedge clk);
    check("hold_en0", observed(), expect_for(8'hAB, 1'b0));

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), 23'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset_a3", 8'hA3);

    // Back-to-back sweep with en held high; valid must stay 1 throughout.
    for (int i = 0; i < 16; i++) begin
      code = 8'hA0 + 8'(i);
      step($sformatf("sweep_%02h", code), code);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
